food_spawner: RTL

//  Consumes the horizontal/vertical pseudo-random LFSR streams and produces a legal food cell
//  for the snake playfield. It advances both LFSRs, range-checks the draw, then queries the

---
 rtl/food_spawner.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/food_spawner.sv
// -----------------------------------------------------------------------------
// food_spawner
//   Picks a legal food cell for the snake playfield. Random draws come from two
//   external LFSRs (RAND_X/RAND_Y), which are advanced with a one-cycle RAND_CE
//   strobe. Each draw is range-checked and then checked against the snake-body
//   occupancy store. After MAX_TRIES rejected draws, the block falls back to a
//   raster scan of the grid. If every cell is occupied it reports FAIL.
//
// Configuration macro: FOOD_AVOID_BORDER_EN
//   Defined   : the outer ring of cells is never chosen. Random draws on the
//               border are rejected, and the scan covers x 1..GRID_W-2,
//               y 1..GRID_H-2.
//   Undefined : the whole grid is legal.
//
// Ports
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   REQ                 spawn request pulse, honoured only in IDLE/DONE
//   RAND_X, RAND_Y      current LFSR values
//   RAND_CE             one-cycle advance strobe to both LFSRs
//   OCC_REQ/OCC_X/OCC_Y occupancy query, held stable until OCC_ACK
//   OCC_ACK, OCC_HIT    occupancy answer (HIT=1 means snake body)
//   FOOD_X, FOOD_Y      last legal food cell, held until the next success
//   FOOD_VALID          level, FOOD_X/Y are valid
//   BUSY                spawn in progress
//   FAIL                level, no free cell exists
// -----------------------------------------------------------------------------
module food_spawner #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int MAX_TRIES = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       REQ,
  input  logic [7:0] RAND_X,
  input  logic [7:0] RAND_Y,
  output logic       RAND_CE,
  output logic       OCC_REQ,
  output logic [7:0] OCC_X,
  output logic [7:0] OCC_Y,
  input  logic       OCC_ACK,
  input  logic       OCC_HIT,
  output logic [7:0] FOOD_X,
  output logic [7:0] FOOD_Y,
  output logic       FOOD_VALID,
  output logic       BUSY,
  output logic       FAIL
);

  // Legal coordinate window. This window serves both the random range check
  // and the scan bounds.
`ifdef FOOD_AVOID_BORDER_EN
  localparam logic [7:0] X_MIN = 8'd1;
  localparam logic [7:0] Y_MIN = 8'd1;
  localparam logic [7:0] X_MAX = 8'(GRID_W - 2);
  localparam logic [7:0] Y_MAX = 8'(GRID_H - 2);
`else
  localparam logic [7:0] X_MIN = 8'd0;
  localparam logic [7:0] Y_MIN = 8'd0;
  localparam logic [7:0] X_MAX = 8'(GRID_W - 1);
  localparam logic [7:0] Y_MAX = 8'(GRID_H - 1);
`endif
  localparam logic [7:0] TRIES_MAX = 8'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DRAW       = 3'd1,
    S_SAMPLE     = 3'd2,
    S_CHECK      = 3'd3,
    S_SCAN       = 3'd4,
    S_SCAN_CHECK = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t     state_r;
  logic [7:0] try_cnt_r;
  logic [7:0] scan_x_r;
  logic [7:0] scan_y_r;
  logic       rand_ce_r;
  logic       occ_req_r;
  logic [7:0] occ_x_r;
  logic [7:0] occ_y_r;
  logic [7:0] food_x_r;
  logic [7:0] food_y_r;
  logic       food_valid_r;
  logic       busy_r;
  logic       fail_r;

  logic       reject_s;
  logic [7:0] try_next_s;

  // Range check of the freshly advanced LFSR values, plus the saturating
  // try-count increment.
  always_comb begin
    reject_s   = 1'b0;
    try_next_s = try_cnt_r;
`ifdef FOOD_AVOID_BORDER_EN
    reject_s = (RAND_X < X_MIN) || (RAND_X > X_MAX) ||
               (RAND_Y < Y_MIN) || (RAND_Y > Y_MAX);
`else
    reject_s = (RAND_X > X_MAX) || (RAND_Y > Y_MAX);
`endif
    if (try_cnt_r != 8'hFF) begin
      try_next_s = try_cnt_r + 8'd1;
    end else begin
      try_next_s = try_cnt_r;
    end
  end

  // Spawn state machine. All outputs are registered here.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= S_IDLE;
      try_cnt_r    <= 8'd0;
      scan_x_r     <= 8'd0;
      scan_y_r     <= 8'd0;
      rand_ce_r    <= 1'b0;
      occ_req_r    <= 1'b0;
      occ_x_r      <= 8'd0;
      occ_y_r      <= 8'd0;
      food_x_r     <= 8'd0;
      food_y_r     <= 8'd0;
      food_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      fail_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (REQ) begin
            state_r      <= S_DRAW;
            rand_ce_r    <= 1'b1;
            busy_r       <= 1'b1;
            food_valid_r <= 1'b0;
            fail_r       <= 1'b0;
            try_cnt_r    <= 8'd0;
          end
        end
        S_DRAW: begin
          // The strobe was raised on entry, so it lasts exactly this cycle.
          rand_ce_r <= 1'b0;
          state_r   <= S_SAMPLE;
        end
        S_SAMPLE: begin
          try_cnt_r <= try_next_s;
          occ_x_r   <= RAND_X;
          occ_y_r   <= RAND_Y;
          if (!reject_s) begin
            occ_req_r <= 1'b1;
            state_r   <= S_CHECK;
          end else if (try_next_s >= TRIES_MAX) begin
            state_r <= S_SCAN;
          end else begin
            rand_ce_r <= 1'b1;
            state_r   <= S_DRAW;
          end
        end
        S_CHECK: begin
          if (OCC_ACK) begin
            occ_req_r <= 1'b0;
            if (!OCC_HIT) begin
              food_x_r     <= occ_x_r;
              food_y_r     <= occ_y_r;
              food_valid_r <= 1'b1;
              busy_r       <= 1'b0;
              state_r      <= S_DONE;
            end else if (try_cnt_r >= TRIES_MAX) begin
              state_r <= S_SCAN;
            end else begin
              rand_ce_r <= 1'b1;
              state_r   <= S_DRAW;
            end
          end
        end
        S_SCAN: begin
          scan_x_r  <= X_MIN;
          scan_y_r  <= Y_MIN;
          occ_x_r   <= X_MIN;
          occ_y_r   <= Y_MIN;
          occ_req_r <= 1'b1;
          state_r   <= S_SCAN_CHECK;
        end
        S_SCAN_CHECK: begin
          // OCC_REQ stays high while the pointer steps. Each ACK consumes
          // the query for the coordinates currently presented.
          if (OCC_ACK) begin
            if (!OCC_HIT) begin
              occ_req_r    <= 1'b0;
              food_x_r     <= occ_x_r;
              food_y_r     <= occ_y_r;
              food_valid_r <= 1'b1;
              busy_r       <= 1'b0;
              state_r      <= S_DONE;
            end else if ((scan_x_r == X_MAX) && (scan_y_r == Y_MAX)) begin
              occ_req_r    <= 1'b0;
              fail_r       <= 1'b1;
              food_valid_r <= 1'b0;
              busy_r       <= 1'b0;
              state_r      <= S_DONE;
            end else if (scan_x_r == X_MAX) begin
              scan_x_r <= X_MIN;
              scan_y_r <= scan_y_r + 8'd1;
              occ_x_r  <= X_MIN;
              occ_y_r  <= scan_y_r + 8'd1;
            end else begin
              scan_x_r <= scan_x_r + 8'd1;
              occ_x_r  <= scan_x_r + 8'd1;
            end
          end
        end
        default: begin
          state_r   <= S_IDLE;
          rand_ce_r <= 1'b0;
          occ_req_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign RAND_CE    = rand_ce_r;
  assign OCC_REQ    = occ_req_r;
  assign OCC_X      = occ_x_r;
  assign OCC_Y      = occ_y_r;
  assign FOOD_X     = food_x_r;
  assign FOOD_Y     = food_y_r;
  assign FOOD_VALID = food_valid_r;
  assign BUSY       = busy_r;
  assign FAIL       = fail_r;

endmodule
